// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - execute-stage request and HI/LO write-port bundle for hilo_muldiv
interface hilo_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        hilo_w_en;
  logic [31:0] hi_w_data;
  logic [31:0] lo_w_data;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, hilo_w_en, hi_w_data, lo_w_data
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, hilo_w_en, hi_w_data, lo_w_data
  );
endinterface

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - multi-cycle MULT/MULTU/DIV/DIVU unit issuing one HI/LO write pulse
module hilo_muldiv #(
  parameter int MUL_LATENCY = 3
) (
  input logic          clk,
  input logic          reset,
  hilo_muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        mul_last;
  logic        div_last;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] dvs;
  logic [32:0] shifted, diff;
  logic [31:0] q_next, r_next;
  logic        quo_neg, rem_neg;

  assign accept   = (state_q == S_IDLE) && bus.start && !bus.cancel;
  assign mul_last = (cnt_q == 5'(MUL_LATENCY - 2));
  assign div_last = (cnt_q == 5'd31);

  // Sign-extending to 64 bits lets one unsigned multiply serve both MULT and MULTU.
  assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  // quo_q starts as the dividend magnitude and is shifted out while quotient bits shift in.
  assign dvs     = (sgn_q && b_q[31]) ? -b_q : b_q;
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_next  = {quo_q[30:0], ~diff[32]};
  assign r_next  = diff[32] ? shifted[31:0] : diff[31:0];
  assign quo_neg = sgn_q && (a_q[31] ^ b_q[31]);
  assign rem_neg = sgn_q && a_q[31];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!bus.op[1])            state_d = S_MUL;
          else if (bus.src_b == '0)  state_d = S_DONE;
          else                       state_d = S_DIV;
        end
      end
      S_MUL: begin
        if (bus.cancel)    state_d = S_IDLE;
        else if (mul_last) state_d = S_DONE;
      end
      S_DIV: begin
        if (bus.cancel)    state_d = S_IDLE;
        else if (div_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers only change on the way into DONE, so they hold between pulses.
  always_comb begin
    sgn_d = sgn_q;
    a_d   = a_q;
    b_d   = b_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sgn_d = ~bus.op[0];
          a_d   = bus.src_a;
          b_d   = bus.src_b;
          cnt_d = '0;
          rem_d = '0;
          quo_d = (!bus.op[0] && bus.src_a[31]) ? -bus.src_a : bus.src_a;
          if (bus.op[1] && bus.src_b == '0) begin
            hi_d = bus.src_a;
            lo_d = '1;
          end
        end
      end
      S_MUL: begin
        if (!bus.cancel) begin
          cnt_d = cnt_q + 5'd1;
          if (mul_last) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end
      end
      S_DIV: begin
        if (!bus.cancel) begin
          cnt_d = cnt_q + 5'd1;
          rem_d = r_next;
          quo_d = q_next;
          if (div_last) begin
            hi_d = rem_neg ? -r_next : r_next;
            lo_d = quo_neg ? -q_next : q_next;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.hilo_w_en = (state_q == S_DONE) && !bus.cancel;
    bus.hi_w_data = hi_q;
    bus.lo_w_data = lo_q;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit that produces the HI/LO write traffic for the CPU's HI and LO registers. It accepts one MULT/MULTU/DIV/DIVU operation at a time from the execute stage. It computes the 64-bit result: the product, or the quotient and remainder. It then issues a single one-cycle write pulse carrying HI and LO data to the HI/LO register write ports.

## Interface
Parameters:
- MUL_LATENCY, default 3: cycles from accept to the write pulse for multiplies. Legal range is 2 to 15.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation. Sampled only when busy=0.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  32  rs operand (multiplicand or dividend).
- src_b  in  32  rt operand (multiplier or divisor).
- cancel  in  1  pipeline flush. Aborts any in-flight operation.
- busy  out  1  high while an operation is in flight, including the write-pulse cycle.
- hilo_w_en  out  1  one-cycle write strobe, driven to both the HI and LO write enables.
- hi_w_data  out  32  HI write data (product[63:32] or remainder).
- lo_w_data  out  32  LO write data (product[31:0] or quotient).

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If start=1 and cancel=0, latch op, src_a and src_b.
  - MULT/MULTU go to MUL.
  - DIV/DIVU with src_b≠0 go to DIV.
  - DIV/DIVU with src_b=0 go directly to DONE.
- MUL:
  - Product computed from the latched operands. MULT is signed 32x32→64; MULTU is unsigned.
  - A counter runs MUL_LATENCY−1 cycles, then the state goes to DONE.
- DIV:
  - Radix-2 restoring division on magnitudes, exactly 32 iterations, one quotient bit per cycle.
  - DIV takes the absolute value of each operand; DIVU uses the operands as-is.
  - Sign fix-up is applied on the final iteration:
    - Quotient is negated when the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Then the state goes to DONE.
- DONE:
  - hilo_w_en = 1 for exactly this cycle, unless cancel=1 in this cycle.
  - Next state is IDLE.
- Divide by zero: HI = src_a, LO = 32'hFFFF_FFFF, for both DIV and DIVU.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- hi_w_data and lo_w_data are registered. They hold their last value outside DONE and are valid only when hilo_w_en=1.
- start while busy=1 is ignored. No queueing, no error.

## Timing
- Reset: state IDLE, busy=0, hilo_w_en=0, hi_w_data=0, lo_w_data=0, counters cleared. Reset mid-operation discards the operation with no write pulse.
- Accept occurs at cycle T, on the edge where start=1, busy=0 and cancel=0. busy=1 from T+1.
- Write pulse cycle:
  - Multiply: T+MUL_LATENCY.
  - Divide: T+33.
  - Divide by zero: T+1.
- busy stays high through the pulse cycle and drops in the following cycle. The earliest next accept is pulse cycle + 1.
- cancel=1 in any non-IDLE cycle: no write pulse. The state is IDLE and busy=0 in the next cycle.
- cancel in DONE suppresses the pulse combinationally in that same cycle.
- cancel together with start in IDLE: cancel wins, and nothing is accepted.
- reset has priority over cancel and start.

## Test plan
- MULT: src_a=0xFFFF_FFFD (−3), src_b=5, MUL_LATENCY=3. Required: hilo_w_en pulse at T+3 only, HI=0xFFFF_FFFF, LO=0xFFFF_FFF1. busy high T+1..T+3 and low at T+4.
- MULTU: 0xFFFF_FFFF × 0xFFFF_FFFF. Required: HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV: −7 / 2. Required: pulse at T+33, LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1).
- DIVU: 100 / 7. Required: LO=0x0000_000E, HI=0x0000_0002.
- DIV 5 / 0: Required: pulse at T+1, HI=0x0000_0005, LO=0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF: Required: LO=0x8000_0000, HI=0.
- DIVU started, cancel at T+10. Required:
  - No pulse at any cycle.
  - busy=0 at T+11.
  - A MULTU started at T+11 completes normally at T+11+MUL_LATENCY.
- start re-asserted at T+5 during a divide, with different operands. Required: ignored; the original result is written at T+33.
- Reset asserted mid-divide. Required: all outputs 0 the next cycle and no pulse.
